// File: rtl/jt7759_pkg.sv
// Shared types and constants for the JT7759 phrase sequencer.
package jt7759_pkg;

  typedef enum logic [3:0] {
    IDLE, HDR, TBL_HI, TBL_LO, DUMMY, CMD, LEN, PLAY, SIL, DONE
  } seq_state_t;

  localparam logic [7:0] CMD_END = 8'h00;
  localparam logic [1:0] OP_SIL  = 2'b00;
  localparam logic [1:0] OP_PLAY = 2'b01;
  localparam logic [1:0] OP_LEN  = 2'b10;
  localparam logic [1:0] OP_REP  = 2'b11;

  localparam int unsigned HDR_TBL_OFS = 5;

  // Address of the big-endian phrase table entry for phrase p
  function automatic logic [16:0] tbl_addr(input logic [7:0] p);
    return 17'(HDR_TBL_OFS) + {8'd0, p, 1'b0};
  endfunction

endpackage

// File: rtl/jt7759_rdreq.sv
// FIFO control-port master: flush pulses, cs/ok byte handshake with re-arm gap.
module jt7759_rdreq (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        flush,
  input  logic [16:0] flush_addr,
  input  logic        req,
  output logic        ack,
  output logic [7:0]  data,
  output logic        ctrl_flush,
  output logic [16:0] ctrl_addr,
  output logic        ctrl_cs,
  input  logic [7:0]  ctrl_din,
  input  logic        ctrl_ok
);

  logic gap;

  // gap keeps cs low for one extra tick after a flush or a completed read,
  // so the FIFO always sees a fresh rising edge of cs
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_flush <= 1'b0;
      ctrl_addr  <= '0;
      ctrl_cs    <= 1'b0;
      ack        <= 1'b0;
      data       <= '0;
      gap        <= 1'b0;
    end else begin
      ctrl_flush <= 1'b0;
      if (cen) begin
        ack <= 1'b0;
        if (flush) begin
          ctrl_flush <= 1'b1;
          ctrl_addr  <= flush_addr;
          ctrl_cs    <= 1'b0;
          gap        <= 1'b1;
        end else if (ctrl_cs) begin
          if (ctrl_ok) begin
            data    <= ctrl_din;
            ack     <= 1'b1;
            ctrl_cs <= 1'b0;
            gap     <= 1'b1;
          end
        end else if (gap) begin
          gap <= 1'b0;
        end else begin
          ctrl_cs <= req;
        end
      end
    end
  end

endmodule

// File: rtl/jt7759_seq.sv
// JT7759 phrase sequencer: header/table walk, command stream, paced nibble output.
// Optional JT7759_REPEAT_EN enables the 11xxxxxx repeat command.
module jt7759_seq
  import jt7759_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 8,
  parameter int unsigned SIL_UNIT   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen_ctl,
  input  logic        start,
  input  logic [7:0]  phrase,
  output logic        busyn,
  output logic        err,
  output logic        ctrl_flush,
  output logic [16:0] ctrl_addr,
  output logic        ctrl_busyn,
  output logic        ctrl_cs,
  input  logic [7:0]  ctrl_din,
  input  logic        ctrl_ok,
  output logic [3:0]  nib,
  output logic        nib_en,
  output logic        dec_rst
);

  localparam int unsigned DW = $clog2(SAMPLE_DIV);
  localparam logic [DW-1:0] DIV_END = DW'(SAMPLE_DIV - 1);

  seq_state_t    state, state_n;
  logic [7:0]    phrase_r, phrase_n, tbl_hi, tbl_hi_n, byte_q, byte_q_n;
  logic [16:0]   base, base_n, flush_addr;
  logic [8:0]    nib_cnt, nib_cnt_n;
  logic [11:0]   sil_cnt, sil_cnt_n;
  logic [DW-1:0] div, div_n;
  logic          have, have_n, lo_phase, lo_phase_n;
  logic          busyn_n, err_n, ctrl_busyn_n, nib_en_n, dec_rst_n;
  logic [3:0]    nib_n;
  logic          flush, want, ack;
  logic [7:0]    rd_data;
`ifdef JT7759_REPEAT_EN
  logic          rep_act, rep_act_n;
  logic [3:0]    rep_cnt, rep_cnt_n;
`endif

  jt7759_rdreq u_rdreq (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen_ctl),
    .flush      (flush),
    .flush_addr (flush_addr),
    .req        (want),
    .ack        (ack),
    .data       (rd_data),
    .ctrl_flush (ctrl_flush),
    .ctrl_addr  (ctrl_addr),
    .ctrl_cs    (ctrl_cs),
    .ctrl_din   (ctrl_din),
    .ctrl_ok    (ctrl_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phrase_r   <= '0;
      tbl_hi     <= '0;
      byte_q     <= '0;
      base       <= '0;
      nib_cnt    <= '0;
      sil_cnt    <= '0;
      div        <= '0;
      have       <= 1'b0;
      lo_phase   <= 1'b0;
      busyn      <= 1'b1;
      err        <= 1'b0;
      ctrl_busyn <= 1'b1;
      nib        <= '0;
      nib_en     <= 1'b0;
      dec_rst    <= 1'b0;
`ifdef JT7759_REPEAT_EN
      rep_act    <= 1'b0;
      rep_cnt    <= '0;
`endif
    end else begin
      state      <= state_n;
      phrase_r   <= phrase_n;
      tbl_hi     <= tbl_hi_n;
      byte_q     <= byte_q_n;
      base       <= base_n;
      nib_cnt    <= nib_cnt_n;
      sil_cnt    <= sil_cnt_n;
      div        <= div_n;
      have       <= have_n;
      lo_phase   <= lo_phase_n;
      busyn      <= busyn_n;
      err        <= err_n;
      ctrl_busyn <= ctrl_busyn_n;
      nib        <= nib_n;
      nib_en     <= nib_en_n;
      dec_rst    <= dec_rst_n;
`ifdef JT7759_REPEAT_EN
      rep_act    <= rep_act_n;
      rep_cnt    <= rep_cnt_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    phrase_n     = phrase_r;
    tbl_hi_n     = tbl_hi;
    byte_q_n     = byte_q;
    base_n       = base;
    nib_cnt_n    = nib_cnt;
    sil_cnt_n    = sil_cnt;
    div_n        = div;
    have_n       = have;
    lo_phase_n   = lo_phase;
    busyn_n      = busyn;
    ctrl_busyn_n = ctrl_busyn;
    nib_n        = nib;
    err_n        = 1'b0;
    nib_en_n     = 1'b0;
    dec_rst_n    = 1'b0;
    flush        = 1'b0;
    flush_addr   = '0;
    want         = 1'b0;
`ifdef JT7759_REPEAT_EN
    rep_act_n    = rep_act;
    rep_cnt_n    = rep_cnt;
`endif
    if (cen_ctl) begin
      if (start) begin
        phrase_n     = phrase;
        flush        = 1'b1;
        state_n      = HDR;
        busyn_n      = 1'b0;
        ctrl_busyn_n = 1'b0;
`ifdef JT7759_REPEAT_EN
        rep_act_n    = 1'b0;
`endif
      end else begin
        case (state)
          IDLE: ;
          HDR: begin
            want = 1'b1;
            if (ack) begin
              if (phrase_r > rd_data) begin
                err_n        = 1'b1;
                busyn_n      = 1'b1;
                ctrl_busyn_n = 1'b1;
                state_n      = IDLE;
              end else begin
                flush      = 1'b1;
                flush_addr = tbl_addr(phrase_r);
                state_n    = TBL_HI;
              end
            end
          end
          TBL_HI: begin
            want = 1'b1;
            if (ack) begin
              tbl_hi_n = rd_data;
              state_n  = TBL_LO;
            end
          end
          TBL_LO: begin
            want = 1'b1;
            if (ack) begin
              base_n     = {tbl_hi, rd_data, 1'b0};
              flush      = 1'b1;
              flush_addr = {tbl_hi, rd_data, 1'b0};
              dec_rst_n  = 1'b1;
              state_n    = DUMMY;
            end
          end
          DUMMY: begin
            want = 1'b1;
            if (ack) state_n = CMD;
          end
          CMD: begin
            want = 1'b1;
            if (ack) begin
              if (rd_data == CMD_END) begin
                state_n = DONE;
              end else begin
                case (rd_data[7:6])
                  OP_SIL: begin
                    sil_cnt_n = 12'(32'(rd_data[5:0]) * SIL_UNIT);
                    div_n     = '0;
                    state_n   = SIL;
                  end
                  OP_PLAY: begin
                    nib_cnt_n  = 9'd256;
                    div_n      = '0;
                    have_n     = 1'b0;
                    lo_phase_n = 1'b0;
                    state_n    = PLAY;
                  end
                  OP_LEN: state_n = LEN;
                  OP_REP: begin
`ifdef JT7759_REPEAT_EN
                    // First sight loads the count; later sights decrement and
                    // jump back until the count reaches zero
                    if (!rep_act) begin
                      rep_act_n  = 1'b1;
                      rep_cnt_n  = {1'b0, rd_data[2:0]} + 4'd1;
                      flush      = 1'b1;
                      flush_addr = base + 17'd1;
                    end else if (rep_cnt == 4'd1) begin
                      rep_act_n  = 1'b0;
                      rep_cnt_n  = '0;
                    end else begin
                      rep_cnt_n  = rep_cnt - 4'd1;
                      flush      = 1'b1;
                      flush_addr = base + 17'd1;
                    end
`else
                    state_n = DONE;
`endif
                  end
                endcase
              end
            end
          end
          LEN: begin
            want = 1'b1;
            if (ack) begin
              nib_cnt_n  = {1'b0, rd_data} + 9'd1;
              div_n      = '0;
              have_n     = 1'b0;
              lo_phase_n = 1'b0;
              state_n    = PLAY;
            end
          end
          PLAY: begin
            // Prefetch the next byte only once both nibbles of the last are out;
            // the divider stalls at its terminal value until the byte arrives
            want = !have && !lo_phase;
            if (ack) begin
              byte_q_n = rd_data;
              have_n   = 1'b1;
            end
            if (div != DIV_END) begin
              div_n = div + DW'(1);
            end else if (lo_phase || have || ack) begin
              nib_en_n   = 1'b1;
              nib_n      = lo_phase ? byte_q[3:0] : (have ? byte_q[7:4] : rd_data[7:4]);
              lo_phase_n = !lo_phase;
              if (lo_phase) have_n = 1'b0;
              nib_cnt_n  = nib_cnt - 9'd1;
              div_n      = '0;
              if (nib_cnt == 9'd1) begin
                have_n     = 1'b0;
                lo_phase_n = 1'b0;
                state_n    = CMD;
              end
            end
          end
          SIL: begin
            if (div != DIV_END) begin
              div_n = div + DW'(1);
            end else begin
              div_n     = '0;
              sil_cnt_n = sil_cnt - 12'd1;
              if (sil_cnt == 12'd1) state_n = CMD;
            end
          end
          DONE: begin
            busyn_n      = 1'b1;
            ctrl_busyn_n = 1'b1;
            state_n      = IDLE;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt7759_seq.sv
// Scoreboard bench for jt7759_seq: ROM-backed FIFO model, event queue, negedge monitor.
module tb_jt7759_seq;

  localparam int unsigned SAMPLE_DIV = 8;
  localparam int unsigned SIL_UNIT   = 32;
  localparam int K_FLUSH = 0, K_DEC = 1, K_ERR = 2, K_NIB = 3;

  logic        clk = 1'b0, rst = 1'b1, cen_ctl = 1'b1, start = 1'b0;
  logic [7:0]  phrase = '0, ctrl_din = '0;
  logic        ctrl_ok = 1'b0;
  logic        busyn, err, ctrl_flush, ctrl_busyn, ctrl_cs, nib_en, dec_rst;
  logic [16:0] ctrl_addr;
  logic [3:0]  nib;

  jt7759_seq #(.SAMPLE_DIV(SAMPLE_DIV), .SIL_UNIT(SIL_UNIT)) dut (
    .clk(clk), .rst(rst), .cen_ctl(cen_ctl), .start(start), .phrase(phrase),
    .busyn(busyn), .err(err), .ctrl_flush(ctrl_flush), .ctrl_addr(ctrl_addr),
    .ctrl_busyn(ctrl_busyn), .ctrl_cs(ctrl_cs), .ctrl_din(ctrl_din), .ctrl_ok(ctrl_ok),
    .nib(nib), .nib_en(nib_en), .dec_rst(dec_rst)
  );

  initial forever #5 clk = ~clk;

  int checks = 0, errors = 0;
  int q_kind[$], q_val[$], nib_cyc[$];
  int cyc = 0;

  // FIFO model: serves rom[ptr] after lat cycles of cs, tracks cs protocol
  logic [7:0]  rom [0:511];
  logic [16:0] ptr = '0;
  int lat = 0, wcnt = 0, cs_drop = 0, cs_stuck = 0;
  bit served = 0, pend = 0;

  initial forever begin
    @(negedge clk);
    ctrl_ok = 1'b0;
    if (ctrl_flush) begin
      ptr = ctrl_addr; served = 0; pend = 0; wcnt = 0;
    end else if (ctrl_cs) begin
      if (served) cs_stuck++;
      else if (wcnt >= lat) begin
        ctrl_ok = 1'b1; ctrl_din = rom[ptr[8:0]]; ptr = ptr + 17'd1;
        served = 1; pend = 0; wcnt = 0;
      end else begin
        wcnt++; pend = 1;
      end
    end else begin
      if (pend) cs_drop++;
      served = 0; pend = 0; wcnt = 0;
    end
  end

  task automatic see(input int k, input int v, input string name);
    int ek, ev;
    checks++;
    if (q_kind.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event, got 0x%0h, required none", name, v);
    end else begin
      ek = q_kind.pop_front();
      ev = q_val.pop_front();
      if (ek != k || ev != v) begin
        errors++;
        $display("FAIL %s got kind %0d value 0x%0h, required kind %0d value 0x%0h", name, k, v, ek, ev);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (ctrl_flush) see(K_FLUSH, int'(ctrl_addr), "flush");
      if (dec_rst)    see(K_DEC, 0, "dec_rst");
      if (err)        see(K_ERR, 0, "err");
      if (nib_en) begin
        see(K_NIB, int'(nib), "nib");
        nib_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic ex(input int k, input int v);
    q_kind.push_back(k);
    q_val.push_back(v);
  endtask

  task automatic ex_head(input int ph, input int base);
    ex(K_FLUSH, 0);
    ex(K_FLUSH, 5 + 2 * ph);
    ex(K_FLUSH, base);
    ex(K_DEC, 0);
  endtask

  task automatic pulse_start(input logic [7:0] p);
    phrase = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!busyn && n < 20000) begin @(negedge clk); n++; end
    check({name, "_done"}, int'(busyn), 1);
    repeat (4) @(negedge clk);
    check({name, "_events_left"}, q_kind.size(), 0);
    q_kind.delete(); q_val.delete();
  endtask

  initial begin
    logic [7:0] b;
    int n, k, g;
    for (int i = 0; i < 512; i++) rom[i] = 8'h00;
    rom[0] = 8'd2;
    rom[5] = 8'h00; rom[6]  = 8'h60;   // phrase 0 -> 0x0C0
    rom[7] = 8'h00; rom[8]  = 8'h10;   // phrase 1 -> 0x020
    rom[9] = 8'h00; rom[10] = 8'h80;   // phrase 2 -> 0x100
    rom[11] = 8'h00; rom[12] = 8'hC0;  // phrase 3 -> 0x180
    rom[9'h20] = 8'hFF; rom[9'h21] = 8'h41;
    for (int i = 0; i < 128; i++) rom[9'h22 + i] = 8'(i * 37 + 5);
    rom[9'hA2] = 8'h00;
    rom[9'hC0] = 8'hEE; rom[9'hC1] = 8'h80; rom[9'hC2] = 8'h04;
    rom[9'hC3] = 8'hA1; rom[9'hC4] = 8'hB2; rom[9'hC5] = 8'hC3; rom[9'hC6] = 8'h00;
    rom[9'h100] = 8'hEE; rom[9'h101] = 8'h80; rom[9'h102] = 8'h00; rom[9'h103] = 8'h5A;
    rom[9'h104] = 8'h02; rom[9'h105] = 8'h80; rom[9'h106] = 8'h00; rom[9'h107] = 8'h6B;
    rom[9'h108] = 8'h00;
    rom[9'h180] = 8'hEE; rom[9'h181] = 8'h80; rom[9'h182] = 8'h01; rom[9'h183] = 8'h12;
    rom[9'h184] = 8'hC1; rom[9'h185] = 8'h00;

    // reset values
    repeat (4) @(negedge clk);
    check("rst_flags", int'({busyn, err, ctrl_flush, ctrl_busyn, ctrl_cs, nib_en, dec_rst}), 'b1001000);
    check("rst_addr", int'(ctrl_addr), 0);
    check("rst_nib", int'(nib), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // normal phrase: 256 nibbles, SAMPLE_DIV apart
    ex_head(1, 'h20);
    for (int i = 0; i < 256; i++) begin
      b = rom[9'h22 + i / 2];
      ex(K_NIB, (i % 2 == 0) ? int'(b[7:4]) : int'(b[3:0]));
    end
    nib_cyc.delete();
    pulse_start(8'd1);
    check("t1_busy_low", int'({busyn, ctrl_busyn}), 0);
    wait_done("t1");
    check("t1_nib_count", nib_cyc.size(), 256);
    if (nib_cyc.size() == 256) check("t1_span", nib_cyc[255] - nib_cyc[0], 255 * SAMPLE_DIV);
    check("t1_ctrl_busyn", int'(ctrl_busyn), 1);

    // out of range: err two cycles after HDR ok, busyn high together with it
    ex(K_FLUSH, 0); ex(K_ERR, 0);
    pulse_start(8'd3);
    #1;
    n = 0;
    while (!ctrl_ok && n < 200) begin @(negedge clk); #1; n++; end
    k = 0;
    do begin @(negedge clk); k++; end while (!busyn && k < 10);
    check("t2_busyn_delay", k, 2);
    wait_done("t2");

    // explicit length 5: A,1,B,2,C (low nibble of 0xC3 dropped)
    ex_head(0, 'hC0);
    ex(K_NIB, 'hA); ex(K_NIB, 'h1); ex(K_NIB, 'hB); ex(K_NIB, 'h2); ex(K_NIB, 'hC);
    pulse_start(8'd0);
    wait_done("t3");

    // silence 2*32 samples between single-nibble plays
    ex_head(2, 'h100);
    ex(K_NIB, 'h5); ex(K_NIB, 'h6);
    nib_cyc.delete();
    pulse_start(8'd2);
    wait_done("t4");
    g = (nib_cyc.size() == 2) ? nib_cyc[1] - nib_cyc[0] : 0;
    check("t4_sil_gap_in_range", int'(g > 64 * SAMPLE_DIV && g <= 64 * SAMPLE_DIV + 48), 1);

    // slow ROM: same 5 nibbles, every byte 40 cycles late
    lat = 40;
    ex_head(0, 'hC0);
    ex(K_NIB, 'hA); ex(K_NIB, 'h1); ex(K_NIB, 'hB); ex(K_NIB, 'h2); ex(K_NIB, 'hC);
    pulse_start(8'd0);
    wait_done("t5");
    lat = 0;

    // restart mid-PLAY after 10 nibbles of phrase 1
    ex_head(1, 'h20);
    for (int i = 0; i < 10; i++) begin
      b = rom[9'h22 + i / 2];
      ex(K_NIB, (i % 2 == 0) ? int'(b[7:4]) : int'(b[3:0]));
    end
    pulse_start(8'd1);
    n = 0;
    while (q_kind.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    check("t6_first_part", q_kind.size(), 0);
    ex_head(0, 'hC0);
    ex(K_NIB, 'hA); ex(K_NIB, 'h1); ex(K_NIB, 'hB); ex(K_NIB, 'h2); ex(K_NIB, 'hC);
    pulse_start(8'd0);
    wait_done("t6");

    // repeat command 0xC1
    rom[0] = 8'd3;
    ex_head(3, 'h180);
    ex(K_NIB, 'h1); ex(K_NIB, 'h2);
`ifdef JT7759_REPEAT_EN
    ex(K_FLUSH, 'h181); ex(K_NIB, 'h1); ex(K_NIB, 'h2);
    ex(K_FLUSH, 'h181); ex(K_NIB, 'h1); ex(K_NIB, 'h2);
`endif
    pulse_start(8'd3);
    wait_done("t7");

    check("cs_dropped_while_pending", cs_drop, 0);
    check("cs_held_after_ok", cs_stuck, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
